activation_loader: RTL and testbench
====================================

// Module: activation_loader
// PURPOSE
//   Input-side producer for the layer-1 neuron array. Takes a pixel stream,
//   one WIDTH_IN-bit pixel per valid/ready beat, and assembles one
//   N_PIX-entry activation vector per frame.
//   Presents the completed vector with an act_valid/act_ready handshake and
//   holds it stable until the consumer accepts it.
//   Checks frame length against s_last and reports errors on frame_err.
// PARAMETERS
//   WIDTH_IN  8    bits per pixel/activation
//   N_PIX     784  activations per frame
//   CW        10   width of fill_level; must satisfy 2**CW > N_PIX
// PORTS
//   clk          in   1                 single clock, all logic on posedge
//   rst_n        in   1                 asynchronous, active-low reset
//   s_valid      in   1                 pixel beat valid
//   s_ready      out  1                 loader can accept a beat
//   s_data       in   WIDTH_IN          pixel value, stored raw (no sign handling)
//   s_last       in   1                 marks the final beat of a frame
//   activations  out  N_PIX*WIDTH_IN    packed [N_PIX-1:0][WIDTH_IN-1:0]; entry k = k-th pixel
//   act_valid    out  1                 activation vector complete and stable
//   act_ready    in   1                 consumer takes the vector
//   frame_err    out  1                 one-cycle pulse on a short or long frame
//   fill_level   out  CW                beats stored in the current frame
// BEHAVIOUR
//   Reset (async assert, sync-release effect): state=FILL, idx=0,
//     activations all 0, act_valid=0, frame_err=0, fill_level=0.
//   s_ready is forced to 0 while rst_n is low.
//   A beat is accepted when s_valid && s_ready on a posedge.
//   s_ready = (state==FILL || state==DRAIN) is a combinational decode of state.
//   State FILL:
//     - Accepted beat writes s_data to activations[idx].
//     - Beat idx<N_PIX-1, s_last=0: idx++.
//     - Beat idx<N_PIX-1, s_last=1 (short frame): frame_err=1 next cycle,
//       idx=0, stay FILL, no act_valid. Stale entries are not cleared.
//     - Beat idx==N_PIX-1, s_last=1: go to HOLD, act_valid=1 next cycle
//       (latency 1 from the last beat).
//     - Beat idx==N_PIX-1, s_last=0 (long frame): frame_err=1 next cycle,
//       go to DRAIN.
//   State DRAIN:
//     - Beats are accepted and discarded; activations are unchanged.
//     - Accepted beat with s_last=1: go to HOLD, act_valid=1 next cycle.
//   State HOLD:
//     - s_ready=0; activations held bit-stable.
//     - act_valid stays 1 until act_ready=1 on a posedge.
//     - On that edge: act_valid=0, idx=0, go to FILL; s_ready=1 next cycle.
//     - No overlap: a new frame never starts in the cycle the vector is
//       accepted.
//   frame_err is exactly one cycle wide per bad frame.
//   fill_level = idx in FILL, N_PIX in DRAIN/HOLD.
//   Reset mid-operation discards any partial frame or held vector.
//   act_valid is never asserted for a frame that was cut by reset.
// TESTING
//   T1 full frame: 784 beats with s_data=k%256, s_last on beat 783
//      -> act_valid rises 1 cycle later; activations[k]==k%256 for all k; frame_err stays 0.
//   T2 backpressure: act_ready=0 for 50 cycles with s_valid=1
//      -> s_ready=0, vector stable; on act_ready=1, act_valid=0 and s_ready=1 next cycle.
//   T3 short frame: s_last on beat 99
//      -> one frame_err pulse, no act_valid, fill_level=0; next 784-beat frame is correct.
//   T4 long frame: 790 beats, s_last on beat 789
//      -> frame_err pulse after beat 783; act_valid after beat 789;
//         activations hold beats 0..783.
//   T5 random s_valid gaps (~50%) plus random act_ready delays over 20 frames
//      -> every vector matches the scoreboard.
//   T6 rst_n low for 3 cycles at beat 400 -> act_valid=0, fill_level=0, activations=0;
//      the following full frame completes correctly.

Source files
------------

// File: rtl/activation_loader.sv
// Assembles one N_PIX-entry activation vector per pixel frame and hands it to the
// layer-1 array over a valid/ready handshake, flagging short and long frames.
module activation_loader #(
    parameter int WIDTH_IN = 8,
    parameter int N_PIX    = 784,
    parameter int CW       = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [WIDTH_IN-1:0]                s_data,
    input  logic                               s_last,
    output logic [N_PIX-1:0][WIDTH_IN-1:0]     activations,
    output logic                               act_valid,
    input  logic                               act_ready,
    output logic                               frame_err,
    output logic [CW-1:0]                      fill_level
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(N_PIX - 1);
    localparam logic [CW-1:0] FULL_LVL = CW'(N_PIX);

    state_t        state;
    logic [CW-1:0] idx;
    logic          accept;

    // Gating with rst_n keeps the stream stalled for the whole reset window.
    assign s_ready    = rst_n && ((state == FILL) || (state == DRAIN));
    assign accept     = s_valid && s_ready;
    assign fill_level = (state == FILL) ? idx : FULL_LVL;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            act_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            if (s_last) begin
                                state     <= HOLD;
                                act_valid <= 1'b1;
                            end else begin
                                state     <= DRAIN;
                                frame_err <= 1'b1;
                            end
                        end else if (s_last) begin
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last) begin
                        state     <= HOLD;
                        act_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (act_ready) begin
                        state     <= FILL;
                        act_valid <= 1'b0;
                        idx       <= '0;
                    end
                end
                default: begin
                    state     <= FILL;
                    act_valid <= 1'b0;
                    idx       <= '0;
                end
            endcase
        end
    end

    // NOTE: the vector store is reset on purpose: a frame cut by reset must
    // leave all-zero activations, so this array cannot be a reset-less RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            activations <= '0;
        end else if (accept && (state == FILL)) begin
            activations[idx] <= s_data;
        end
    end

endmodule

// File: tb/tb_activation_loader.sv
// Directed bench for activation_loader: a frame-level model pushes expected vectors
// into a scoreboard queue that is popped each time the loader presents a vector.
module tb_activation_loader;

    localparam int W  = 8;
    localparam int N  = 784;
    localparam int CW = 10;

    logic                    clk;
    logic                    rst_n;
    logic                    s_valid;
    logic                    s_ready;
    logic [W-1:0]            s_data;
    logic                    s_last;
    logic [N-1:0][W-1:0]     activations;
    logic                    act_valid;
    logic                    act_ready;
    logic                    frame_err;
    logic [CW-1:0]           fill_level;

    activation_loader #(.WIDTH_IN(W), .N_PIX(N), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .activations(activations),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .frame_err  (frame_err),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;

    // Counts every cycle in which frame_err was high; a clean pulse adds exactly one.
    always @(posedge clk) if (frame_err === 1'b1) err_cnt = err_cnt + 1;

    logic [W-1:0]          model [N];
    int                    m_idx;
    bit                    m_drain;
    logic [N*W-1:0]        exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [N*W-1:0] exp);
        logic [N*W-1:0] got;
        int k;
        got = activations;
        k = 0;
        for (int i = N - 1; i >= 0; i--)
            if (got[i*W +: W] !== exp[i*W +: W]) k = i;
        check($sformatf("%s[%0d]", tag, k), 32'(got[k*W +: W]), 32'(exp[k*W +: W]));
    endtask

    function automatic logic [N*W-1:0] model_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = model[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) model[i] = '0;
        m_idx   = 0;
        m_drain = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input logic [W-1:0] data, input logic last);
        int n;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        n = 0;
        while (s_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("beat_wait_timeout", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Sends n beats (s_last on beat last_at, -1 for none), updating the model
    // and checking the per-beat consequences the frame rules predict.
    task automatic send_frame(input int n, input int last_at, input int base, input bit gaps);
        logic [W-1:0] d;
        bit           l;
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(1) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            d = W'((k + base) % 256);
            l = (k == last_at);
            send_beat(d, l);
            if (!m_drain) begin
                model[m_idx] = d;
                if (m_idx == N - 1) begin
                    if (l) begin
                        exp_q.push_back(model_vec());
                        m_idx = 0;
                        check("act_valid_latency", 32'(act_valid), 32'd1);
                    end else begin
                        m_drain = 1'b1;
                        check("long_frame_err", 32'(frame_err), 32'd1);
                        check("drain_fill_level", 32'(fill_level), N);
                    end
                end else if (l) begin
                    m_idx = 0;
                    check("short_frame_err", 32'(frame_err), 32'd1);
                    check("short_fill_level", 32'(fill_level), 32'd0);
                end else begin
                    m_idx++;
                end
            end else if (l) begin
                exp_q.push_back(model_vec());
                m_drain = 1'b0;
                m_idx   = 0;
                check("drain_act_valid", 32'(act_valid), 32'd1);
            end
        end
    endtask

    task automatic take_vector(input int delay);
        int n;
        n = 0;
        while (act_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("act_valid_wait", 32'(act_valid), 32'd1);
        check("hold_fill_level", 32'(fill_level), N);
        check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_vec("act", exp_q.pop_front());
        repeat (delay) @(negedge clk);
        act_ready = 1'b1;
        @(negedge clk);
        act_ready = 1'b0;
        check("act_valid_drop", 32'(act_valid), 32'd0);
        check("s_ready_after_take", 32'(s_ready), 32'd1);
    endtask

    int err_base;

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        act_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_act_valid", 32'(act_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_fill_level", 32'(fill_level), 32'd0);
        check_vec("rst_act", model_vec());
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);

        // T1: full frame, data = k % 256
        err_base = err_cnt;
        send_frame(N, N - 1, 0, 1'b0);
        take_vector(0);
        check("t1_no_frame_err", 32'(err_cnt - err_base), 32'd0);

        // T2: vector held stable under backpressure with a pending beat
        send_frame(N, N - 1, 13, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("t2_s_ready_low", 32'(s_ready), 32'd0);
            check("t2_act_valid_held", 32'(act_valid), 32'd1);
            if (c % 10 == 9) check_vec("t2_stable", exp_q[0]);
        end
        s_valid = 1'b0;
        take_vector(0);

        // T3: short frame, then a clean frame
        err_base = err_cnt;
        send_frame(100, 99, 50, 1'b0);
        repeat (3) @(negedge clk);
        check("t3_no_act_valid", 32'(act_valid), 32'd0);
        check("t3_one_err_pulse", 32'(err_cnt - err_base), 32'd1);
        check("t3_fill_level", 32'(fill_level), 32'd0);
        send_frame(N, N - 1, 101, 1'b0);
        take_vector(2);

        // T4: long frame of 790 beats keeps beats 0..783
        err_base = err_cnt;
        send_frame(N + 6, N + 5, 200, 1'b0);
        take_vector(1);
        check("t4_one_err_pulse", 32'(err_cnt - err_base), 32'd1);

        // T5: random gaps and random consumer delays
        err_base = err_cnt;
        for (int f = 0; f < 20; f++) begin
            send_frame(N, N - 1, int'($urandom_range(255)), 1'b1);
            take_vector(int'($urandom_range(6)));
        end
        check("t5_no_frame_err", 32'(err_cnt - err_base), 32'd0);

        // T6: reset at beat 400 discards the partial frame
        send_frame(400, -1, 77, 1'b0);
        check("t6_fill_before_rst", 32'(fill_level), 32'd400);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("t6_rst_act_valid", 32'(act_valid), 32'd0);
        check("t6_rst_fill_level", 32'(fill_level), 32'd0);
        check("t6_rst_s_ready", 32'(s_ready), 32'd0);
        check_vec("t6_rst_act", model_vec());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_s_ready_back", 32'(s_ready), 32'd1);
        send_frame(N, N - 1, 3, 1'b0);
        take_vector(0);
        check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
